// File: rtl/byte_lane_packer.sv
// Packs lane-tagged bytes into 16-bit byte-enabled words for the holding register.
// A word is released on in_last, a lane collision, or TIMEOUT idle cycles while half-filled.

module byte_lane_packer_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       en
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      en <= 1'b0;
    end else if (clr) begin
      q  <= '0;
      en <= 1'b0;
    end else if (wr) begin
      q  <= din;
      en <= 1'b1;
    end
  end
endmodule

module byte_lane_packer #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_hi,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_d,
  output logic [1:0]  out_byteena,
  output logic [15:0] word_count
);
  localparam int NUM_LANES = 2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2} state_t;

  state_t                          state;
  logic [7:0]                      timer;
  logic [NUM_LANES-1:0][7:0]       lane_q;
  logic [NUM_LANES-1:0]            lane_en;
  logic                            accept, handoff, collide, illegal;

  // in_ready is combinational on in_hi so a collision is refused in the same cycle
  always_comb begin
    in_ready = rst_n & ((state == EMPTY) | ((state == PARTIAL) & ~lane_en[in_hi]));
    accept   = in_valid & in_ready;
    collide  = (state == PARTIAL) & in_valid & lane_en[in_hi];
    handoff  = (state == FULL) & out_ready;
    illegal  = !(state inside {EMPTY, PARTIAL, FULL});
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    byte_lane_packer_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (accept & (in_hi == (g == 1))),
      .clr   (handoff | illegal),
      .din   (in_data),
      .q     (lane_q[g]),
      .en    (lane_en[g])
    );
  end

  assign out_valid   = (state == FULL);
  assign out_d       = lane_q;
  assign out_byteena = lane_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      timer      <= '0;
      word_count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            timer <= '0;
            state <= in_last ? FULL : PARTIAL;
          end
        end
        PARTIAL: begin
          if (accept || collide)       state <= FULL;
          else if (timer == TO_LAST)   state <= FULL;
          else                         timer <= timer + 8'd1;
        end
        FULL: begin
          if (handoff) begin
            word_count <= word_count + 16'd1;
            timer      <= '0;
            state      <= EMPTY;
          end
        end
        default: begin
          timer <= '0;
          state <= EMPTY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_byte_lane_packer.sv
// Self-checking bench for byte_lane_packer: directed vector table, corner sequences, random vs model.
module tb_byte_lane_packer;
  localparam int TO = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_hi = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid;
  logic [15:0] out_d, word_count;
  logic [1:0]  out_byteena;

  int tests = 0, fails = 0;

  byte_lane_packer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_hi(in_hi), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_d(out_d), .out_byteena(out_byteena), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, hi, last; logic [7:0] d; logic ordy;
    logic rdy, ov; logic [15:0] od; logic [1:0] be; logic [15:0] cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic hi, input logic last, input logic [7:0] d,
                       input logic ordy);
    in_valid = v; in_hi = hi; in_last = last; in_data = d; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: bytes held per lane, a pending-word flag and an idle-cycle count
  logic [7:0]  m_lane[2];
  logic [1:0]  m_pres;
  logic        m_full;
  int          m_idle;
  logic [15:0] m_cnt;

  initial begin
    int n, quiet;
    logic v, hi, last, ordy, erdy;
    logic [7:0] d;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 16'h55AA, 2'b11, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'd1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 16'h3C00, 2'b10, 16'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 16'h3C00, 2'b10, 16'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 16'h0011, 2'b01, 16'd2};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'd3};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 16'h0022, 2'b01, 16'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'd4};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_byteena", 32'(out_byteena), 32'd0);
    chk("rst_out_d", 32'(out_d), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].hi, tbl[i].last, tbl[i].d, tbl[i].ordy);
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_out_d", i), 32'(out_d), 32'(tbl[i].od));
        chk($sformatf("vec%0d_byteena", i), 32'(out_byteena), 32'(tbl[i].be));
      end
      chk($sformatf("vec%0d_word_count", i), 32'(word_count), 32'(tbl[i].cnt));
    end

    // timeout: out_valid rises TO cycles after the lone accept
    drive(1'b1, 1'b0, 1'b0, 8'h7E, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("timeout_cycles", 32'(n), 32'(TO));
    chk("timeout_out_d", 32'(out_d), 32'h007E);
    chk("timeout_byteena", 32'(out_byteena), 32'b01);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("timeout_handoff_cnt", 32'(word_count), 32'd5);

    // backpressure: word held stable for 5 cycles
    drive(1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h02, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_d", 32'(out_d), 32'h0201);
      chk("bp_byteena", 32'(out_byteena), 32'b11);
      chk("bp_word_count", 32'(word_count), 32'd5);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("bp_release_cnt", 32'(word_count), 32'd6);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // asynchronous reset mid-word
    drive(1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_byteena", 32'(out_byteena), 32'd0);
    chk("arst_word_count", 32'(word_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
    tick();
    chk("arst_pair_valid", 32'(out_valid), 32'd1);
    chk("arst_pair_d", 32'(out_d), 32'h0201);
    chk("arst_pair_be", 32'(out_byteena), 32'b11);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("arst_pair_cnt", 32'(word_count), 32'd1);

    // randomized run against the model
    m_pres = 2'b00; m_full = 1'b0; m_idle = 0; m_cnt = 16'd1;
    m_lane[0] = 8'h00; m_lane[1] = 8'h00;
    quiet = 0;
    for (int c = 0; c < 600; c++) begin
      if (quiet == 0 && $urandom_range(0, 15) == 0) quiet = $urandom_range(4, 12);
      v    = (quiet == 0) && ($urandom_range(0, 3) != 0);
      if (quiet > 0) quiet--;
      hi   = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 7) == 0);
      d    = 8'($urandom);
      ordy = ($urandom_range(0, 2) != 0);
      drive(v, hi, last, d, ordy);

      erdy = m_full ? 1'b0 : (m_pres == 2'b00) ? 1'b1 : !m_pres[hi];
      #1 chk("rand_in_ready", 32'(in_ready), 32'(erdy));

      if (m_full) begin
        if (ordy) begin m_cnt++; m_full = 1'b0; m_pres = 2'b00; end
      end else if (v && erdy) begin
        m_lane[hi] = d; m_pres[hi] = 1'b1; m_idle = 0;
        if (m_pres == 2'b11 || last) m_full = 1'b1;
      end else if (m_pres != 2'b00) begin
        if (v) m_full = 1'b1;
        else begin
          m_idle++;
          if (m_idle == TO) m_full = 1'b1;
        end
      end

      tick();
      chk("rand_out_valid", 32'(out_valid), 32'(m_full));
      if (m_full) begin
        chk("rand_out_d", 32'(out_d),
            32'({(m_pres[1] ? m_lane[1] : 8'h00), (m_pres[0] ? m_lane[0] : 8'h00)}));
        chk("rand_byteena", 32'(out_byteena), 32'(m_pres));
      end
      chk("rand_word_count", 32'(word_count), 32'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/byte_lane_packer.md
Name: byte_lane_packer

Overview:
Upstream feeder for the byte-enabled 16-bit holding register. Accepts a stream of single bytes, each tagged with a target lane, and packs them into 16-bit words with a 2-bit byte-enable. Presents each word on a valid/ready output whose out_d / out_byteena connect directly to the register's d / byteena inputs. Partial words are flushed on an explicit last marker, a lane collision, or an idle timeout.

Parameters:
TIMEOUT, 8, idle cycles in PARTIAL before a forced flush of a half-filled word (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input byte valid
in_ready  output  1  packer can accept the byte this cycle
in_data  input  8  input byte
in_hi  input  1  target lane: 0 = bits [7:0], 1 = bits [15:8]
in_last  input  1  flush the word after accepting this byte
out_valid  output  1  packed word available
out_ready  input  1  downstream accepts the word
out_d  output  16  packed data; unwritten lane reads 0
out_byteena  output  2  bit0 = lower lane written, bit1 = upper lane written
word_count  output  16  number of words handed off since reset; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY, hold data = 0, byteena = 00, timer = 0, word_count = 0. While rst_n is low, out_valid = 0 and in_ready = 0. Reset mid-operation discards any partial or pending word; no handoff is counted.
- Accept on an input: in_valid & in_ready at a rising clk edge. Handoff on the output: out_valid & out_ready at a rising clk edge.
- EMPTY: in_ready = 1.
  - On accept: write in_data into the selected lane, set the matching byteena bit, clear the timer.
  - Next state is FULL if in_last = 1, otherwise PARTIAL.
- PARTIAL: in_ready = 1 only when the lane selected by in_hi is unoccupied. This is a combinational path from in_hi.
  - Accept into the free lane: write the lane, set its bit, go to FULL (in_last is irrelevant here).
  - in_valid with in_hi selecting the occupied lane (collision): in_ready = 0, the byte is not taken, go to FULL next cycle. The byte is offered again later.
  - No accept this cycle: timer increments. When the timer equals TIMEOUT-1 with no accept, go to FULL. The total idle time in PARTIAL is exactly TIMEOUT cycles.
  - An accept in the same cycle as the timeout takes priority and completes the word normally.
- FULL: in_ready = 0 and out_valid = 1.
  - out_d and out_byteena are registered and stable while out_valid & !out_ready.
  - On handoff: word_count increments, hold data clears to 0, byteena clears to 00, timer clears, next state is EMPTY.
  - There is no same-cycle accept of a new byte during a handoff (one bubble per word).
- Latency: the byte that completes a word is accepted at edge N, and out_valid is high after edge N. A full word throughput therefore needs a minimum of 3 cycles.
- out_byteena is never 00 while out_valid = 1.
- State encoding is free. Only EMPTY, PARTIAL and FULL exist; any illegal encoding recovers to EMPTY.

Test Plan:
- Reset then two bytes: 0xAA with in_hi=0, then 0x55 with in_hi=1, out_ready=1 -> one handoff of out_d=0x55AA, out_byteena=11; word_count=1; out_valid high exactly 1 cycle.
- Single byte 0x3C with in_hi=1 and in_last=1 -> out_d=0x3C00, out_byteena=10 on the next cycle; in_ready=0 until the handoff.
- Collision: 0x11 with in_hi=0, then 0x22 with in_hi=0 -> in_ready=0 for 0x22 and out_d=0x0011, byteena=01 handed off. 0x22 is then accepted and later emitted with byteena=01.
- Timeout (TIMEOUT=8): 0x7E with in_hi=0, then no input -> out_valid rises exactly 8 cycles after the accept, with out_d=0x007E, byteena=01.
- Backpressure: complete a word with out_ready=0 for 5 cycles -> out_d/out_byteena unchanged, in_ready=0, word_count unchanged until out_ready=1. It then increments by exactly 1.
- Reset mid-word: accept 0x99 with in_hi=1, pulse rst_n low asynchronously between edges -> out_valid=0, byteena=00, word_count=0 immediately. After release, the next 0x01 (in_hi=0) + 0x02 (in_hi=1) pair yields 0x0201.
